// File: rtl/phase2iq.sv
// phase2iq: iterative rotation-mode CORDIC turning (angle, amplitude) into an (I,Q) pair.
// One micro-rotation per clock behind a start/busy/done handshake; x/y hold until the next done.
module phase2iq #(
    parameter int INPUTBITSIZE  = 13,
    parameter int OUTPUTBITSIZE = 19,
    parameter int ITERATIONS    = 11,
    parameter int GUARD         = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic signed [OUTPUTBITSIZE-1:0] angle,
    input  logic signed [INPUTBITSIZE-1:0]  ampl,
    output logic signed [INPUTBITSIZE-1:0]  x,
    output logic signed [INPUTBITSIZE-1:0]  y
);
    localparam int DW = INPUTBITSIZE + GUARD + 1;
    localparam int PW = INPUTBITSIZE + 16;
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic signed [OUTPUTBITSIZE-1:0] ZMAX     = OUTPUTBITSIZE'(3217);
    localparam logic signed [OUTPUTBITSIZE-1:0] ZMIN     = OUTPUTBITSIZE'(-3217);
    localparam logic signed [OUTPUTBITSIZE-1:0] HALF_POS = OUTPUTBITSIZE'(1608);
    localparam logic signed [OUTPUTBITSIZE-1:0] HALF_NEG = OUTPUTBITSIZE'(-1608);
    localparam logic signed [PW-1:0]            KSCALE   = PW'(19899);
    localparam logic signed [DW:0]              RND      = (DW+1)'(2 ** (GUARD - 1));
    localparam logic signed [DW:0]              OMAX     = (DW+1)'(2 ** (INPUTBITSIZE - 1) - 1);
    localparam logic signed [DW:0]              OMIN     = (DW+1)'(-(2 ** (INPUTBITSIZE - 1)));

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t                          state, state_next;
    logic signed [OUTPUTBITSIZE-1:0] angle_r, z, z_clamp, z_fold, z_next;
    logic signed [INPUTBITSIZE-1:0]  ampl_r;
    logic signed [PW-1:0]            prod;
    logic signed [DW-1:0]            ak, xr, yr, x_fold, y_fold, x_next, y_next, x_sh, y_sh;
    logic [IW-1:0]                   iter;

    function automatic logic signed [OUTPUTBITSIZE-1:0] atan_q10(input int idx);
        logic signed [OUTPUTBITSIZE-1:0] v;
        case (idx)
            0:       v = OUTPUTBITSIZE'(804);
            1:       v = OUTPUTBITSIZE'(475);
            2:       v = OUTPUTBITSIZE'(251);
            3:       v = OUTPUTBITSIZE'(127);
            4:       v = OUTPUTBITSIZE'(64);
            5:       v = OUTPUTBITSIZE'(32);
            6:       v = OUTPUTBITSIZE'(16);
            7:       v = OUTPUTBITSIZE'(8);
            8:       v = OUTPUTBITSIZE'(4);
            9:       v = OUTPUTBITSIZE'(2);
            10:      v = OUTPUTBITSIZE'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Drop the guard bits with round-half-up, then clip to the output range.
    function automatic logic signed [INPUTBITSIZE-1:0] round_sat(input logic signed [DW-1:0] v);
        logic signed [DW:0] t;
        t = ((DW+1)'(v) + RND) >>> GUARD;
        if (t > OMAX)
            return INPUTBITSIZE'(OMAX);
        if (t < OMIN)
            return INPUTBITSIZE'(OMIN);
        return INPUTBITSIZE'(t);
    endfunction

    // Start-up vector: clamp, remove CORDIC gain up front, and fold into the convergence range.
    always_comb begin
        z_clamp = angle_r;
        if (angle_r > ZMAX)
            z_clamp = ZMAX;
        else if (angle_r < ZMIN)
            z_clamp = ZMIN;

        prod = PW'(ampl_r) * KSCALE;
        ak   = DW'(prod >>> 15) <<< GUARD;

        x_fold = ak;
        y_fold = '0;
        z_fold = z_clamp;
        if (z_clamp > HALF_POS) begin
            x_fold = '0;
            y_fold = ak;
            z_fold = z_clamp - HALF_POS;
        end else if (z_clamp < HALF_NEG) begin
            x_fold = '0;
            y_fold = -ak;
            z_fold = z_clamp - HALF_NEG;
        end
    end

    always_comb begin
        x_sh = xr >>> iter;
        y_sh = yr >>> iter;
        if (!z[OUTPUTBITSIZE-1]) begin
            x_next = xr - y_sh;
            y_next = yr + x_sh;
            z_next = z - atan_q10(int'(iter));
        end else begin
            x_next = xr + y_sh;
            y_next = yr - x_sh;
            z_next = z + atan_q10(int'(iter));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = S_LOAD;
            end
            S_LOAD:  state_next = S_ITER;
            S_ITER: begin
                if (iter == IW'(ITERATIONS - 1))
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            angle_r <= '0;
            ampl_r  <= '0;
            xr      <= '0;
            yr      <= '0;
            z       <= '0;
            iter    <= '0;
            x       <= '0;
            y       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        angle_r <= angle;
                        ampl_r  <= ampl;
                    end
                end
                S_LOAD: begin
                    xr   <= x_fold;
                    yr   <= y_fold;
                    z    <= z_fold;
                    iter <= '0;
                end
                S_ITER: begin
                    xr   <= x_next;
                    yr   <= y_next;
                    z    <= z_next;
                    iter <= iter + 1'b1;
                end
                S_DONE: begin
                    x    <= round_sat(xr);
                    y    <= round_sat(yr);
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_phase2iq.sv
// tb_phase2iq: randomized and directed checks of phase2iq against an integer CORDIC model
// built from the algorithm description, plus handshake, latency and reset-abort behaviour.
module tb_phase2iq;
    logic               clock;
    logic               reset;
    logic               start;
    logic               busy;
    logic               done;
    logic signed [18:0] angle;
    logic signed [12:0] ampl;
    logic signed [12:0] x;
    logic signed [12:0] y;

    int compared = 0;
    int mismatched = 0;

    phase2iq dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy (busy),
        .done (done),
        .angle(angle),
        .ampl (ampl),
        .x    (x),
        .y    (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int v, input int lo, input int hi);
        checkOutput($sformatf("%s=%0d in [%0d,%0d]", tag, v, lo, hi), int'(v >= lo && v <= hi), 1);
    endtask

    // Reference: clamp, gain pre-scale, quadrant fold, 11 shift-add rotations, round, saturate.
    function automatic void model(input int ang, input int amp, output int ex, output int ey);
        int     atan_tab[11] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1};
        longint xv, yv, zv, ak, xs, ys, t;
        zv = ang;
        if (zv > 3217)  zv = 3217;
        if (zv < -3217) zv = -3217;
        ak = (longint'(amp) * 19899) >>> 15;
        ak = ak * 8;
        if (zv > 1608) begin
            xv = 0; yv = ak; zv = zv - 1608;
        end else if (zv < -1608) begin
            xv = 0; yv = -ak; zv = zv + 1608;
        end else begin
            xv = ak; yv = 0;
        end
        for (int i = 0; i < 11; i++) begin
            xs = xv >>> i;
            ys = yv >>> i;
            if (zv >= 0) begin
                xv = xv - ys; yv = yv + xs; zv = zv - atan_tab[i];
            end else begin
                xv = xv + ys; yv = yv - xs; zv = zv + atan_tab[i];
            end
        end
        t  = (xv + 4) >>> 3;
        ex = (t > 4095) ? 4095 : (t < -4096) ? -4096 : int'(t);
        t  = (yv + 4) >>> 3;
        ey = (t > 4095) ? 4095 : (t < -4096) ? -4096 : int'(t);
    endfunction

    task automatic applyStimulus(input int ang, input int amp, output int ox, output int oy);
        int lat;
        angle = 19'(ang);
        ampl  = 13'(amp);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        checkOutput($sformatf("latency a=%0d A=%0d", ang, amp), lat, 13);
        ox = x;
        oy = y;
    endtask

    task automatic runModel(input string tag, input int ang, input int amp, input int ref_ang);
        int ox, oy, ex, ey;
        model(ref_ang, amp, ex, ey);
        applyStimulus(ang, amp, ox, oy);
        checkOutput($sformatf("%s x a=%0d A=%0d", tag, ang, amp), ox, ex);
        checkOutput($sformatf("%s y a=%0d A=%0d", tag, ang, amp), oy, ey);
    endtask

    initial begin
        int ox, oy, ex1, ey1, ex2, ey2, ndone, a, m;
        int dcyc[$];

        reset = 1'b1;
        start = 1'b0;
        angle = '0;
        ampl  = '0;
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset x", int'(x), 0);
        checkOutput("reset y", int'(y), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // Directed accuracy points.
        applyStimulus(0, 4000, ox, oy);
        checkRange("t1 x", ox, 3997, 4003);
        checkRange("t1 y", oy, -3, 3);
        applyStimulus(1608, 4000, ox, oy);
        checkRange("t2a x", ox, -3, 3);
        checkRange("t2a y", oy, 3997, 4003);
        applyStimulus(-3217, 4000, ox, oy);
        checkRange("t2b x", ox, -4003, -3997);
        checkRange("t2b y", oy, -3, 3);
        applyStimulus(804, 4095, ox, oy);
        checkRange("t3 x", ox, 2893, 2899);
        checkRange("t3 y", oy, 2893, 2899);

        // Exact results, including clamping and fold boundaries.
        runModel("exact", 0, 4000, 0);
        runModel("exact", 804, 4095, 804);
        runModel("clamp+", 5000, 4095, 3217);
        runModel("clamp-", -20000, 3000, -3217);
        runModel("fold", 1609, 3500, 1609);
        runModel("fold", -1609, 3500, -1609);
        runModel("fold", -1608, -2000, -1608);
        runModel("zero", 1234, 0, 1234);
        checkOutput("ampl0 x", int'(x), 0);
        checkOutput("ampl0 y", int'(y), 0);
        runModel("neg4096", 0, -4096, 0);
        runModel("neg4096", 2500, -4096, 2500);
        runModel("max", -900, 4095, -900);

        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(8000)) - 4000;
            m = int'($urandom_range(8191)) - 4096;
            runModel("rand", a, m, a);
        end

        // Start held high: one done per 14 cycles; inputs changed mid-flight are not re-sampled.
        model(-700, 3100, ex1, ey1);
        model(2900, -1800, ex2, ey2);
        angle = -19'sd700;
        ampl  = 13'sd3100;
        start = 1'b1;
        @(posedge clock); #1;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock); #1;
            if (c == 2) begin
                angle = 19'sd2900;
                ampl  = -13'sd1800;
            end
            if (done === 1'b1) begin
                checkOutput($sformatf("hold done#%0d cycle", ndone), c, 13 + 14 * ndone);
                if (ndone == 0) begin
                    checkOutput("hold x0", int'(x), ex1);
                    checkOutput("hold y0", int'(y), ey1);
                end else begin
                    checkOutput($sformatf("hold x%0d", ndone), int'(x), ex2);
                    checkOutput($sformatf("hold y%0d", ndone), int'(y), ey2);
                end
                ndone++;
            end
        end
        checkOutput("hold done count", ndone, 4);
        start = 1'b0;
        repeat (20) @(posedge clock);
        #1;

        // Reset in the middle of ITER aborts without a done pulse.
        runModel("prerst", 1000, 3000, 1000);
        angle = -19'sd2000;
        ampl  = 13'sd2500;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("busy after start", int'(busy), 1);
        repeat (6) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort x", int'(x), 0);
        checkOutput("abort y", int'(y), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            if (done === 1'b1)
                ndone++;
        end
        checkOutput("abort no done", ndone, 0);
        runModel("postrst", -2000, 2500, -2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
